// File: rtl/adc_resp_pkg.sv
// adc_resp_pkg: shared FSM states and field widths for the MCP3008-style SPI ADC responder
package adc_resp_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_START, CMD, SAMPLE, DATA, DONE} state_t;
  localparam int CMD_BITS = 4;
  localparam int CH_W = 3;
  localparam int DEF_DATA_W = 10;
endpackage

// File: rtl/adc_responder_pin_sync.sv
// spi_pin_sync: STAGES-flop pin synchroniser with rise/fall detect; ports i_clk,i_rst_n,i_pin -> o_level,o_rise,o_fall
module spi_pin_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = STAGES'({sync_q, i_pin});
    prev_d = sync_q[STAGES-1];
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  assign o_level = sync_q[STAGES-1];
  assign o_rise = o_level & ~prev_q;
  assign o_fall = ~o_level & prev_q;
endmodule

// File: rtl/adc_responder.sv
// adc_responder: SPI responder emulating an 8-ch MCP3008-style ADC; ports i_clk,i_rst_n,i_samples,p_clk,p_cs,p_in -> p_out,o_busy,o_channel,o_single,o_frame_done; option ADC_RESP_LSB_TAIL_EN
module adc_responder
  import adc_resp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CHANNELS = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [CHANNELS*DATA_W-1:0]   i_samples,
  input  logic                         p_clk,
  input  logic                         p_cs,
  input  logic                         p_in,
  output logic                         p_out,
  output logic                         o_busy,
  output logic [CH_W-1:0]              o_channel,
  output logic                         o_single,
  output logic                         o_frame_done
);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic [CH_W-1:0] channel_q, channel_d;
  logic single_q, single_d, pout_q, pout_d, done_q, done_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, in_pos, in_neg, result;
  logic [DATA_W:0] diff;
  logic sclk_rise, sclk_fall, cs_lvl, din_lvl;
  logic sclk_lvl_unused, cs_rise_unused, cs_fall_unused, din_rise_unused, din_fall_unused;
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(p_clk),
    .o_level(sclk_lvl_unused), .o_rise(sclk_rise), .o_fall(sclk_fall));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(p_cs),
    .o_level(cs_lvl), .o_rise(cs_rise_unused), .o_fall(cs_fall_unused));
  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(p_in),
    .o_level(din_lvl), .o_rise(din_rise_unused), .o_fall(din_fall_unused));
  assign in_pos = i_samples[int'(channel_q)*DATA_W +: DATA_W];
  assign in_neg = i_samples[int'({channel_q[CH_W-1:1], ~channel_q[0]})*DATA_W +: DATA_W];
  assign diff = {1'b0, in_pos} - {1'b0, in_neg};
  assign result = single_q ? in_pos : (diff[DATA_W] ? '0 : diff[DATA_W-1:0]);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cmd_d = cmd_q;
    channel_d = channel_q;
    single_d = single_q;
    pout_d = pout_q;
    done_d = 1'b0;
    shreg_d = shreg_q;
    if (cs_lvl) begin
      state_d = IDLE;
      cnt_d = '0;
      pout_d = 1'b0;
    end else
      case (state_q)
        IDLE: begin
          state_d = WAIT_START;
          cnt_d = '0;
        end
        WAIT_START: if (sclk_rise && din_lvl) begin
          state_d = CMD;
          cnt_d = '0;
        end
        CMD: if (sclk_rise) begin
          cmd_d = {cmd_q[CMD_BITS-2:0], din_lvl};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
            state_d = SAMPLE;
            channel_d = cmd_d[CH_W-1:0];
            single_d = cmd_d[CH_W];
          end
        end
        SAMPLE: if (sclk_fall) begin
          shreg_d = result;
          pout_d = 1'b0;
          cnt_d = '0;
          state_d = DATA;
        end
        DATA: if (sclk_fall) begin
          pout_d = shreg_q[DATA_W-1];
          shreg_d = {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = DONE;
            done_d = 1'b1;
            cnt_d = '0;
          end
        end
`ifdef ADC_RESP_LSB_TAIL_EN
        DONE: if (sclk_fall) begin
          pout_d = cnt_q < CNT_W'(DATA_W - 1) ? shreg_q[1] : 1'b0;
          shreg_d = shreg_q >> 1;
          cnt_d = cnt_q < CNT_W'(DATA_W - 1) ? cnt_q + 1'b1 : cnt_q;
        end
`else
        DONE: if (sclk_fall) pout_d = 1'b0;
`endif
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cmd_q <= '0;
      channel_q <= '0;
      single_q <= 1'b0;
      pout_q <= 1'b0;
      done_q <= 1'b0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cmd_q <= cmd_d;
      channel_q <= channel_d;
      single_q <= single_d;
      pout_q <= pout_d;
      done_q <= done_d;
      shreg_q <= shreg_d;
    end
  assign p_out = pout_q;
  assign o_busy = state_q != IDLE;
  assign o_channel = channel_q;
  assign o_single = single_q;
  assign o_frame_done = done_q;
endmodule

// File: tb/tb_adc_responder.sv
// tb_adc_responder: scoreboard bench driving SPI frames and checking DOUT bits and per-frame status against a reference model
module tb_adc_responder;
  localparam int DW = 10;
  localparam int SS = 2;
  localparam int H = 80;
  typedef struct {int done; int ch; int sgl;} meta_t;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic p_clk = 1'b0;
  logic p_cs = 1'b1;
  logic p_in = 1'b0;
  logic [8*DW-1:0] i_samples = '0;
  logic p_out, o_busy, o_single, o_frame_done;
  logic [2:0] o_channel;
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int model_ch = 0;
  int model_sgl = 0;
  int exp_bits[$];
  meta_t exp_meta[$];
  always #5 i_clk = ~i_clk;
  adc_responder dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_samples(i_samples),
    .p_clk(p_clk), .p_cs(p_cs), .p_in(p_in), .p_out(p_out),
    .o_busy(o_busy), .o_channel(o_channel), .o_single(o_single),
    .o_frame_done(o_frame_done));
  always @(posedge i_clk) if (o_frame_done) done_cnt++;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic int smp(input int c);
    logic [DW-1:0] v;
    v = i_samples[c*DW +: DW];
    return int'(v);
  endfunction
  function automatic int ref_result(input int sgl, input int ch);
    int p, m;
    p = smp(ch);
    m = smp(ch ^ 1);
    return sgl != 0 ? p : (p >= m ? p - m : 0);
  endfunction
  task automatic set_ch(input int c, input int v);
    i_samples[c*DW +: DW] = DW'(v);
  endtask
  task automatic rand_samples();
    for (int c = 0; c < 8; c++) set_ch(c, int'($urandom_range(1023, 0)));
  endtask
  task automatic frame(input int lead, input int sgl, input int ch, input int extra,
                       input int stop_fall, input bit use_rst, input bit hold_chg);
    int r, nclk, e, j;
    int din[$];
    meta_t m;
    r = ref_result(sgl, ch);
    for (int k = 0; k < lead; k++) din.push_back(0);
    din.push_back(1);
    din.push_back(sgl);
    din.push_back((ch >> 2) & 1);
    din.push_back((ch >> 1) & 1);
    din.push_back(ch & 1);
    nclk = stop_fall > 0 ? stop_fall : lead + 16 + extra;
    @(negedge i_clk);
    #2;
    p_cs = 1'b0;
    #40;
    for (int k = 0; k < nclk; k++) begin
      e = 0;
      if (k >= lead + 6 && k <= lead + 15) e = (r >> (lead + 15 - k)) & 1;
`ifdef ADC_RESP_LSB_TAIL_EN
      j = k - lead - 16;
      if (j >= 0 && j < DW - 1) e = (r >> (j + 1)) & 1;
`endif
      p_in = k < din.size() ? din[k][0] : 1'b0;
      exp_bits.push_back(e);
      #H;
      p_clk = 1'b1;
      if (hold_chg && k == lead + 8) rand_samples();
      #H;
      p_clk = 1'b0;
    end
    p_in = 1'b0;
    if (!use_rst && nclk >= lead + 5) begin
      model_ch = ch;
      model_sgl = sgl;
    end
    if (use_rst) begin
      #40;
      i_rst_n = 1'b0;
      #1;
      chk("rst_p_out", int'(p_out), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_frame_done", int'(o_frame_done), 0);
      model_ch = 0;
      model_sgl = 0;
      m = '{done: 0, ch: 0, sgl: 0};
      exp_meta.push_back(m);
      #20;
      p_cs = 1'b1;
      #20;
      i_rst_n = 1'b1;
    end else begin
      m = '{done: nclk >= lead + 15 ? 1 : 0, ch: model_ch, sgl: model_sgl};
      exp_meta.push_back(m);
      #H;
      p_cs = 1'b1;
    end
    #120;
  endtask
  initial forever begin
    @(posedge p_clk);
    #1;
    if (exp_bits.size() == 0) chk("p_out_unexpected_edge", 1, 0);
    else chk("p_out_bit", int'(p_out), exp_bits.pop_front());
  end
  initial begin
    int base;
    meta_t m;
    base = 0;
    forever begin
      @(posedge p_cs);
      repeat (SS + 2) @(posedge i_clk);
      #1;
      if (exp_meta.size() > 0) begin
        m = exp_meta.pop_front();
        chk("idle_p_out", int'(p_out), 0);
        chk("idle_busy", int'(o_busy), 0);
        chk("frame_done_count", done_cnt - base, m.done);
        chk("o_channel", int'(o_channel), m.ch);
        chk("o_single", int'(o_single), m.sgl);
      end
      base = done_cnt;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int lead, stop;
    #23;
    chk("reset_p_out", int'(p_out), 0);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_channel", int'(o_channel), 0);
    chk("reset_single", int'(o_single), 0);
    chk("reset_frame_done", int'(o_frame_done), 0);
    i_rst_n = 1'b1;
    #50;
    rand_samples();
    set_ch(5, 'h2A5);
    frame(0, 1, 5, 0, 0, 1'b0, 1'b0);
    set_ch(2, 700);
    set_ch(3, 200);
    frame(0, 0, 2, 0, 0, 1'b0, 1'b0);
    frame(0, 0, 3, 0, 0, 1'b0, 1'b0);
    frame(3, 1, 5, 0, 0, 1'b0, 1'b0);
    frame(0, 1, 5, 0, 7, 1'b0, 1'b0);
    frame(0, 1, 5, 0, 0, 1'b0, 1'b0);
    frame(0, 1, 5, 9, 0, 1'b0, 1'b0);
    frame(0, 0, 2, 0, 0, 1'b0, 1'b1);
    set_ch(5, 'h2A5);
    frame(0, 1, 5, 0, 10, 1'b1, 1'b0);
    frame(1, 1, 5, 2, 0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      rand_samples();
      lead = int'($urandom_range(3, 0));
      stop = $urandom_range(3, 0) == 0 ? int'($urandom_range(lead + 15, 1)) : 0;
      frame(lead, int'($urandom_range(1, 0)), int'($urandom_range(7, 0)),
            int'($urandom_range(11, 0)), stop, 1'b0, 1'($urandom_range(1, 0)));
    end
    #200;
    chk("bits_consumed", exp_bits.size(), 0);
    chk("frames_consumed", exp_meta.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
